spi_slave_if: RTL and testbench

//  Serial front end of the SPI slave: deserialises MOSI frames into 10-bit {cmd,data} words for the

---
 rtl/spi_pkg.sv | 9 +
 rtl/spi_tx_shifter.sv | 33 +++
 rtl/spi_slave_if.sv | 107 ++++++++++
 tb/tb_spi_slave_if.sv | 118 +++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: state encoding, command codes and frame width shared by the SPI slave, RAM and wrapper
package spi_pkg;
  localparam int FRM_W = 10;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  typedef enum logic [2:0] {IDLE, RECV, WAIT_TX, SEND, DONE} state_t;
endpackage

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: parallel-load MSB-first PISO for the MISO path
module spi_tx_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         next_bit,
  output logic         bit_done
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  logic [W-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sh_d = load ? din : shift ? {sh_q[W-2:0], 1'b0} : sh_q;
    cnt_d = load ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
  end
  // next_bit is what the registered miso takes on this edge
  assign next_bit = load ? din[W-1] : sh_q[W-2];
  assign bit_done = (cnt_q == LAST);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q <= sh_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front end; MOSI frames to {cmd,data} words, RAM read data back out on MISO
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int CMD_W  = 2,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ss_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic [CMD_W+DATA_W-1:0] rx_data,
  output logic                    rx_valid,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_valid
);
  localparam int FW = CMD_W + DATA_W;
  localparam logic [3:0] LAST_BIT = 4'(FW - 1);
  state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [FW-1:0] shift_q, shift_d, rx_data_q, rx_data_d, frame;
  logic [CMD_W-1:0] cmd;
  logic rx_valid_q, rx_valid_d, rd_pend_q, rd_pend_d, miso_q, miso_d;
  logic ld, sh, nxt, done;
  assign frame = {shift_q[FW-2:0], mosi};
  assign cmd = frame[FW-1 -: CMD_W];
  spi_tx_shifter #(.W(DATA_W)) u_tx (
    .clk(clk), .rst(rst), .load(ld), .shift(sh), .din(tx_data), .next_bit(nxt), .bit_done(done)
  );
  always_comb begin
    state_d = state_q;
    bit_cnt_d = '0;
    shift_d = shift_q;
    rx_data_d = rx_data_q;
    rx_valid_d = 1'b0;
    rd_pend_d = rd_pend_q;
    miso_d = 1'b0;
    ld = 1'b0;
    sh = 1'b0;
    if (ss_n) begin
      state_d = IDLE;
      if (state_q == WAIT_TX || state_q == SEND) rd_pend_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          shift_d = frame;
          bit_cnt_d = 4'd1;
          state_d = RECV;
        end
        RECV: begin
          shift_d = frame;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            rx_data_d = frame;
            state_d = DONE;
            // a read-data request without a pending read address is dropped
            if (cmd == CMD_RD_DATA) begin
              if (rd_pend_q) begin
                rx_valid_d = 1'b1;
                state_d = WAIT_TX;
              end
            end else begin
              rx_valid_d = 1'b1;
              if (cmd == CMD_RD_ADDR) rd_pend_d = 1'b1;
            end
          end
        end
        WAIT_TX: if (tx_valid) begin
          ld = 1'b1;
          miso_d = nxt;
          rd_pend_d = 1'b0;
          state_d = SEND;
        end
        SEND: if (done) state_d = DONE;
        else begin
          sh = 1'b1;
          miso_d = nxt;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      shift_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      rd_pend_q <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rd_pend_q <= rd_pend_d;
      miso_q <= miso_d;
    end
  end
  assign miso = miso_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed frames with an rx scoreboard monitor and inline MISO checks
module tb_spi_slave_if;
  logic clk = 1'b0, rst = 1'b1, ss_n = 1'b1, mosi = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] pat;
  logic miso, rx_valid;
  logic [9:0] rx_data;
  logic [9:0] exp_q[$];
  logic [9:0] e;
  logic rv_prev = 1'b0;
  int checks = 0, errors = 0;
  spi_slave_if dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic s, input logic m);
    ss_n = s;
    mosi = m;
    @(negedge clk);
  endtask
  task automatic frame(input logic [9:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, f[9-i]);
      chk("rx_miso", {9'b0, miso}, 10'h000);
    end
  endtask
  task automatic gap();
    cyc(1'b1, 1'b0);
  endtask
  initial forever begin
    @(negedge clk);
    if (!rst && rx_valid) begin
      if (rv_prev) chk("rx_valid_width", 10'h002, 10'h001);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got rx_data=%h with rx_valid, required no strobe", rx_data);
      end else begin
        e = exp_q.pop_front();
        chk("rx_data", rx_data, e);
      end
    end
    rv_prev = rx_valid && !rst;
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_miso", {9'b0, miso}, 10'h000);
    chk("rst_rx_valid", {9'b0, rx_valid}, 10'h000);
    chk("rst_rx_data", rx_data, 10'h000);
    rst = 1'b0;
    gap();
    exp_q.push_back(10'h005); frame(10'h005, 10); gap();
    exp_q.push_back(10'h1A5); frame(10'h1A5, 10); gap();
    exp_q.push_back(10'h205); frame(10'h205, 10); gap();
    frame(10'h3FF, 5);
    ss_n = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_miso", {9'b0, miso}, 10'h000);
    chk("arst_rx_valid", {9'b0, rx_valid}, 10'h000);
    chk("arst_rx_data", rx_data, 10'h000);
    @(negedge clk);
    rst = 1'b0;
    gap();
    frame(10'h300, 10); gap();
    exp_q.push_back(10'h005); frame(10'h005, 10); gap();
    exp_q.push_back(10'h205); frame(10'h205, 10); gap();
    exp_q.push_back(10'h300); frame(10'h300, 10);
    repeat (2) begin cyc(1'b0, 1'b0); chk("wait_miso", {9'b0, miso}, 10'h000); end
    pat = 8'hA5;
    tx_data = pat; tx_valid = 1'b1; cyc(1'b0, 1'b0); tx_valid = 1'b0;
    chk("tx_a5_b7", {9'b0, miso}, 10'h001);
    for (int i = 6; i >= 0; i--) begin
      cyc(1'b0, 1'b1);
      chk("tx_a5_bit", {9'b0, miso}, {9'b0, pat[i]});
    end
    cyc(1'b0, 1'b0); chk("tx_end_miso", {9'b0, miso}, 10'h000);
    repeat (3) begin cyc(1'b0, 1'b1); chk("done_miso", {9'b0, miso}, 10'h000); end
    gap();
    frame(10'h300, 10);
    frame(10'h001, 10);
    gap();
    frame(10'h1FF, 6); gap();
    exp_q.push_back(10'h003); frame(10'h003, 10); gap();
    frame(10'h2AA, 9); gap();
    exp_q.push_back(10'h0AA); frame(10'h0AA, 10); gap();
    tx_data = 8'hFF; tx_valid = 1'b1;
    cyc(1'b1, 1'b0); chk("idle_txv_miso", {9'b0, miso}, 10'h000);
    exp_q.push_back(10'h210); frame(10'h210, 10); gap();
    exp_q.push_back(10'h2FF); frame(10'h2FF, 10); gap();
    exp_q.push_back(10'h300); frame(10'h300, 10);
    tx_valid = 1'b0;
    cyc(1'b0, 1'b0); chk("wait2_miso", {9'b0, miso}, 10'h000);
    pat = 8'h3C;
    tx_data = pat; tx_valid = 1'b1; cyc(1'b0, 1'b0); tx_valid = 1'b0;
    chk("tx_3c_b7", {9'b0, miso}, {9'b0, pat[7]});
    for (int i = 6; i >= 4; i--) begin
      cyc(1'b0, 1'b0);
      chk("tx_3c_bit", {9'b0, miso}, {9'b0, pat[i]});
    end
    cyc(1'b1, 1'b0); chk("abort_miso", {9'b0, miso}, 10'h000);
    frame(10'h300, 10);
    tx_valid = 1'b1; cyc(1'b0, 1'b0); tx_valid = 1'b0;
    chk("nopend_miso", {9'b0, miso}, 10'h000);
    repeat (3) gap();
    chk("sb_empty", 10'(exp_q.size()), 10'h000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
